pool_output_drain: RTL and testbench

- Read-side master for the pooled-output SRAM port of the pool array.
- After a layer finishes, a `start` pulse makes it sweep the valid output region row by row, `OUTPUT_SRAM_LEN` columns per read.
- Captures `SRAM_out` one cycle after each read and streams the words to the downstream output buffer over a valid/ready handshake.
- A 2-entry skid FIFO absorbs backpressure, so no read data is lost.

---
 rtl/pool_output_drain_pkg.sv | 35 +++
 rtl/pool_output_drain_if.sv | 34 +++
 rtl/pool_output_drain_skid_fifo.sv | 75 +++++++
 rtl/pool_output_drain.sv | 205 ++++++++++++++++++++
 tb/tb_pool_output_drain.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pool_output_drain_pkg.sv
// Shared types for the pooled-output drain: FSM states, per-word payload
// carried through the skid FIFO, and lane geometry taken from the system
// defines (fallback values are supplied when the defines are absent).
`ifndef OUTPUT_HEIGHT
`define OUTPUT_HEIGHT 4
`endif
`ifndef OUTPUT_WIDTH
`define OUTPUT_WIDTH 8
`endif
`ifndef OUTPUT_SRAM_LEN
`define OUTPUT_SRAM_LEN 4
`endif
`ifndef BIN_LEN
`define BIN_LEN 8
`endif

package drain_pkg;

  localparam int LANES = `OUTPUT_SRAM_LEN;
  localparam int BW    = `BIN_LEN;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_t;

  typedef struct packed {
    logic [BW*LANES-1:0] data;
    logic [LANES-1:0]    mask;
    logic                last;
  } drain_word_t;

endpackage

// File: rtl/pool_output_drain_if.sv
// Bus bundle between the drain and its neighbours: the read port of the
// pool array SRAM and the valid/ready stream to the output buffer.
interface pool_output_drain_if #(
  parameter int H     = `OUTPUT_HEIGHT,
  parameter int W     = `OUTPUT_WIDTH,
  parameter int LANES = `OUTPUT_SRAM_LEN,
  parameter int BW    = `BIN_LEN
);

  logic                   SRAM_r_en;
  logic [$clog2(H)-1:0]   SRAM_r;
  logic [$clog2(W)-1:0]   SRAM_c;
  logic [BW*LANES-1:0]    SRAM_out;
  logic                   out_valid;
  logic                   out_ready;
  logic [BW*LANES-1:0]    out_data;
  logic [LANES-1:0]       out_mask;
  logic                   out_last;

  modport master (
    output SRAM_r_en, SRAM_r, SRAM_c,
    input  SRAM_out,
    output out_valid, out_data, out_mask, out_last,
    input  out_ready
  );

  modport slave (
    input  SRAM_r_en, SRAM_r, SRAM_c,
    output SRAM_out,
    input  out_valid, out_data, out_mask, out_last,
    output out_ready
  );

endinterface

// File: rtl/pool_output_drain_skid_fifo.sv
// Two-entry skid FIFO of drain words. Entry 0 is always the head. When the
// FIFO is empty a word being pushed is presented at the head in the same
// cycle, so a simultaneous push and pop on an empty FIFO flows straight
// through without being stored.
module drain_skid_fifo
  import drain_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        push_i,
  input  drain_word_t push_word_i,
  input  logic        pop_i,
  output drain_word_t head_o,
  output logic [1:0]  count_o,
  output logic        empty_o,
  output logic        full_o
);

  drain_word_t mem0_q, mem0_d;
  drain_word_t mem1_q, mem1_d;
  logic [1:0]  count_q, count_d;

  assign count_o = count_q;
  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign head_o  = !empty_o ? mem0_q : (push_i ? push_word_i : '0);

  // Next storage contents and occupancy for every push/pop combination
  always_comb begin
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (count_q == 2'd0) begin
          mem0_d  = push_word_i;
          count_d = 2'd1;
        end else if (count_q == 2'd1) begin
          mem1_d  = push_word_i;
          count_d = 2'd2;
        end
      end
      2'b01: begin
        if (count_q != 2'd0) begin
          mem0_d  = mem1_q;
          count_d = count_q - 2'd1;
        end
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          mem0_d = push_word_i;
        end else if (count_q == 2'd2) begin
          mem0_d = mem1_q;
          mem1_d = push_word_i;
        end
      end
      default: begin
      end
    endcase
  end

  // Storage and occupancy registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem0_q  <= '0;
      mem1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pool_output_drain.sv
// Read-side master that sweeps the valid pooled-output region of the pool
// array SRAM row by row and streams each read word downstream over a
// valid/ready handshake. A two-entry skid FIFO plus an in-flight read flag
// bound outstanding data to two words, so backpressure never loses data.
// Build option: DRAIN_ZERO_PAD_EN forces masked-off lanes of out_data to 0.
module pool_output_drain #(
  parameter int H     = `OUTPUT_HEIGHT,
  parameter int W     = `OUTPUT_WIDTH,
  parameter int LANES = `OUTPUT_SRAM_LEN,
  parameter int BW    = `BIN_LEN
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [$clog2(H+1)-1:0]    rows_valid,
  input  logic [$clog2(W+1)-1:0]    cols_valid,
  pool_output_drain_if.master       bus,
  output logic                      busy,
  output logic                      done
);

  import drain_pkg::*;

  localparam int RW  = $clog2(H);
  localparam int CW  = $clog2(W);
  localparam int RVW = $clog2(H+1);
  localparam int CVW = $clog2(W+1);

  drain_state_t      state_q, state_d;
  logic [RVW-1:0]    rows_q, rows_d;
  logic [CVW-1:0]    cols_q, cols_d;
  logic [RW-1:0]     row_q, row_d;
  logic [CW-1:0]     col_q, col_d;
  logic              inflight_q;
  logic [LANES-1:0]  mask_q;
  logic              last_q;

  logic              issue;
  logic              pop;
  logic              out_valid;
  logic [1:0]        occ_next;
  logic              last_col;
  logic              last_row;
  logic [LANES-1:0]  mask_now;
  logic [BW*LANES-1:0] cap_data;

  drain_word_t       push_word;
  drain_word_t       head;
  logic [1:0]        fifo_count;
  logic              fifo_empty;
  logic              fifo_full;

`ifdef DRAIN_ZERO_PAD_EN
  function automatic logic [BW*LANES-1:0] zero_pad(
    input logic [BW*LANES-1:0] d,
    input logic [LANES-1:0]    m
  );
    logic [BW*LANES-1:0] r;
    r = d;
    for (int i = 0; i < LANES; i++) begin
      if (!m[i]) r[i*BW +: BW] = '0;
    end
    return r;
  endfunction

  assign cap_data = zero_pad(bus.SRAM_out, mask_q);
`else
  assign cap_data = bus.SRAM_out;
`endif

  // A word is handed downstream either from the FIFO head or straight from
  // the read that lands this cycle.
  assign out_valid = !fifo_empty || inflight_q;
  assign pop       = out_valid && bus.out_ready;

  // Occupancy left after this cycle; a read issued now lands next cycle.
  assign occ_next  = fifo_count + {1'b0, inflight_q} - {1'b0, pop};

  assign last_col  = (int'(col_q) + LANES) >= int'(cols_q);
  assign last_row  = (int'(row_q) + 1) >= int'(rows_q);

  // Lane-valid mask for the read at the current column
  always_comb begin
    mask_now = '0;
    for (int i = 0; i < LANES; i++) begin
      mask_now[i] = (int'(col_q) + i) < int'(cols_q);
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (rows_valid == '0 || cols_valid == '0) state_d = DONE;
          else                                      state_d = READ;
        end
      end
      READ:    if (issue && last_row && last_col) state_d = FLUSH;
      FLUSH:   if (occ_next == 2'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: read request, busy and done
  always_comb begin
    issue = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      READ: begin
        issue = (occ_next < 2'd2);
        busy  = 1'b1;
      end
      FLUSH: busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Sweep bounds latched at start; row/column advance per issued read
  always_comb begin
    rows_d = rows_q;
    cols_d = cols_q;
    row_d  = row_q;
    col_d  = col_q;
    if (state_q == IDLE && start) begin
      rows_d = rows_valid;
      cols_d = cols_valid;
      row_d  = '0;
      col_d  = '0;
    end else if (issue) begin
      if (last_col) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + CW'(LANES);
      end
    end
  end

  // Sweep registers plus issue-stage metadata that travels with each read
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rows_q     <= '0;
      cols_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      inflight_q <= 1'b0;
      mask_q     <= '0;
      last_q     <= 1'b0;
    end else begin
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      row_q      <= row_d;
      col_q      <= col_d;
      inflight_q <= issue;
      if (issue) begin
        mask_q <= mask_now;
        last_q <= last_row && last_col;
      end
    end
  end

  assign push_word.data = cap_data;
  assign push_word.mask = mask_q;
  assign push_word.last = last_q;

  drain_skid_fifo u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (inflight_q),
    .push_word_i (push_word),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  // A landing read must always find room in the FIFO
  assert property (@(posedge clock) disable iff (!reset)
    !(fifo_full && inflight_q && !pop));

  assign bus.SRAM_r_en = issue;
  assign bus.SRAM_r    = row_q;
  assign bus.SRAM_c    = col_q;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = head.data;
  assign bus.out_mask  = head.mask;
  assign bus.out_last  = head.last;

endmodule

// File: tb/tb_pool_output_drain.sv
module tb_pool_output_drain;

  localparam int H = 4;
  localparam int W = 8;
  localparam int L = 4;
  localparam int B = 8;

  logic        clock;
  logic        reset;
  logic        start;
  logic [2:0]  rows_valid;
  logic [3:0]  cols_valid;
  logic        busy;
  logic        done;
  logic        rdy;
  logic [31:0] sram_q;
  int          cyc;
  int          n_checks;
  int          n_fail;

  pool_output_drain_if #(.H(H), .W(W), .LANES(L), .BW(B)) bus ();

  pool_output_drain #(.H(H), .W(W), .LANES(L), .BW(B)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .rows_valid (rows_valid),
    .cols_valid (cols_valid),
    .bus        (bus),
    .busy       (busy),
    .done       (done)
  );

  assign bus.out_ready = rdy;
  assign bus.SRAM_out  = sram_q;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Lane j of the word at (r,c) holds {r, c+j} as two nibbles
  function automatic logic [31:0] mk_word(input int r, input int c);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 4; j++) w[j*8 +: 8] = 8'((r << 4) | (c + j));
    return w;
  endfunction

  function automatic logic [31:0] exp_data(input int r, input int c, input int cols);
    logic [31:0] w;
    w = mk_word(r, c);
`ifdef DRAIN_ZERO_PAD_EN
    for (int j = 0; j < 4; j++) if (c + j >= cols) w[j*8 +: 8] = 8'h00;
`endif
    return w;
  endfunction

  // SRAM read port: data one cycle after the request, Z otherwise
  always @(posedge clock) begin
    if (bus.SRAM_r_en) sram_q <= mk_word(int'(bus.SRAM_r), int'(bus.SRAM_c));
    else               sram_q <= 'z;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int          rd_cyc[$];
  int          rd_r[$];
  int          rd_c[$];
  int          ac_cyc[$];
  logic [31:0] ac_data[$];
  logic [3:0]  ac_mask[$];
  logic        ac_last[$];
  int          done_cyc[$];
  logic        hold_pending;
  logic [31:0] hold_data;
  logic [3:0]  hold_mask;
  logic        hold_last;

  // Trace reads, accepted words and done pulses; check stability under stall
  always @(negedge clock) begin
    if (reset) begin
      if (bus.SRAM_r_en) begin
        rd_cyc.push_back(cyc);
        rd_r.push_back(int'(bus.SRAM_r));
        rd_c.push_back(int'(bus.SRAM_c));
      end
      if (bus.out_valid && bus.out_ready) begin
        ac_cyc.push_back(cyc);
        ac_data.push_back(bus.out_data);
        ac_mask.push_back(bus.out_mask);
        ac_last.push_back(bus.out_last);
      end
      if (done) done_cyc.push_back(cyc);
      if (hold_pending) begin
        check("hold_valid", 64'(bus.out_valid), 64'd1);
        check("hold_data", 64'(bus.out_data), 64'(hold_data));
        check("hold_mask", 64'(bus.out_mask), 64'(hold_mask));
        check("hold_last", 64'(bus.out_last), 64'(hold_last));
      end
      hold_pending = bus.out_valid && !bus.out_ready;
      hold_data    = bus.out_data;
      hold_mask    = bus.out_mask;
      hold_last    = bus.out_last;
    end else begin
      hold_pending = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    rd_cyc.delete(); rd_r.delete(); rd_c.delete();
    ac_cyc.delete(); ac_data.delete(); ac_mask.delete(); ac_last.delete();
    done_cyc.delete();
  endtask

  task automatic go(input int r, input int c, output int s);
    rows_valid = 3'(r);
    cols_valid = 4'(c);
    start = 1'b1;
    tick();
    start = 1'b0;
    s = cyc;
  endtask

  // Full-rate sweep: read i at s+i, word i accepted at s+1+i, done at s+n+1
  task automatic expect_sweep(input string tag, input int s, input int rows, input int cols);
    int wpr, n, r, c;
    logic [3:0] m;
    wpr = (cols + 3) / 4;
    n   = rows * wpr;
    check($sformatf("%s_nreads", tag), 64'(rd_cyc.size()), 64'(n));
    check($sformatf("%s_nwords", tag), 64'(ac_cyc.size()), 64'(n));
    check($sformatf("%s_ndone", tag), 64'(done_cyc.size()), 64'd1);
    for (int i = 0; i < n && i < rd_cyc.size(); i++) begin
      check($sformatf("%s_rd%0d_row", tag, i), 64'(rd_r[i]), 64'(i / wpr));
      check($sformatf("%s_rd%0d_col", tag, i), 64'(rd_c[i]), 64'((i % wpr) * 4));
      check($sformatf("%s_rd%0d_cyc", tag, i), 64'(rd_cyc[i] - s), 64'(i));
    end
    for (int i = 0; i < n && i < ac_cyc.size(); i++) begin
      r = i / wpr;
      c = (i % wpr) * 4;
      for (int j = 0; j < 4; j++) m[j] = (c + j < cols);
      check($sformatf("%s_w%0d_data", tag, i), 64'(ac_data[i]), 64'(exp_data(r, c, cols)));
      check($sformatf("%s_w%0d_mask", tag, i), 64'(ac_mask[i]), 64'(m));
      check($sformatf("%s_w%0d_last", tag, i), 64'(ac_last[i]), 64'(i == n - 1));
      check($sformatf("%s_w%0d_cyc", tag, i), 64'(ac_cyc[i] - s), 64'(i + 1));
    end
    if (done_cyc.size() > 0)
      check($sformatf("%s_done_cyc", tag), 64'(done_cyc[0] - s), 64'(n + 1));
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_r_en"}, 64'(bus.SRAM_r_en), 64'd0);
    check({tag, "_r"}, 64'(bus.SRAM_r), 64'd0);
    check({tag, "_c"}, 64'(bus.SRAM_c), 64'd0);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_data"}, 64'(bus.out_data), 64'd0);
    check({tag, "_mask"}, 64'(bus.out_mask), 64'd0);
    check({tag, "_last"}, 64'(bus.out_last), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    int s;
    int exp_rd[6];
    int exp_ac[6];
    n_checks     = 0;
    n_fail       = 0;
    cyc          = 0;
    hold_pending = 1'b0;
    start        = 1'b0;
    rows_valid   = '0;
    cols_valid   = '0;
    rdy          = 1'b1;
    reset        = 1'b1;
    #2 reset = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset");
    reset = 1'b1;
    tick();

    // 2 rows x 8 columns at full rate
    clr();
    go(2, 8, s);
    repeat (8) tick();
    expect_sweep("t1", s, 2, 8);
    if (ac_data.size() == 4) begin
      check("t1_w0_hand", 64'(ac_data[0]), 64'h03020100);
      check("t1_w3_hand", 64'(ac_data[3]), 64'h17161514);
    end

    // 1 row x 6 columns: partial second word
    clr();
    go(1, 6, s);
    repeat (6) tick();
    expect_sweep("t2", s, 1, 6);
    if (ac_data.size() == 2) begin
      check("t2_mask1", 64'(ac_mask[1]), 64'h3);
`ifdef DRAIN_ZERO_PAD_EN
      check("t2_w1_pad", 64'(ac_data[1]), 64'h00000504);
`else
      check("t2_w1_raw", 64'(ac_data[1]), 64'h07060504);
`endif
    end

    // 3 rows x 8 columns with a 5-cycle stall after the second word
    clr();
    go(3, 8, s);
    repeat (3) tick();
    rdy = 1'b0;
    repeat (5) tick();
    rdy = 1'b1;
    repeat (7) tick();
    exp_rd = '{0, 1, 2, 3, 8, 9};
    exp_ac = '{1, 2, 8, 9, 10, 11};
    check("t3_nreads", 64'(rd_cyc.size()), 64'd6);
    check("t3_nwords", 64'(ac_cyc.size()), 64'd6);
    for (int i = 0; i < 6 && i < rd_cyc.size(); i++) begin
      check($sformatf("t3_rd%0d_cyc", i), 64'(rd_cyc[i] - s), 64'(exp_rd[i]));
      check($sformatf("t3_rd%0d_rc", i), 64'((rd_r[i] << 4) | rd_c[i]), 64'(((i / 2) << 4) | ((i % 2) * 4)));
    end
    for (int i = 0; i < 6 && i < ac_cyc.size(); i++) begin
      check($sformatf("t3_w%0d_cyc", i), 64'(ac_cyc[i] - s), 64'(exp_ac[i]));
      check($sformatf("t3_w%0d_data", i), 64'(ac_data[i]), 64'(mk_word(i / 2, (i % 2) * 4)));
      check($sformatf("t3_w%0d_last", i), 64'(ac_last[i]), 64'(i == 5));
    end
    if (ac_data.size() == 6) check("t3_w5_hand", 64'(ac_data[5]), 64'h27262524);
    check("t3_ndone", 64'(done_cyc.size()), 64'd1);
    if (done_cyc.size() > 0) check("t3_done_cyc", 64'(done_cyc[0] - s), 64'd12);

    // Empty region: rows=0, then cols=0
    clr();
    check("t4_busy_pre", 64'(busy), 64'd0);
    go(0, 8, s);
    @(negedge clock);
    check("t4_done", 64'(done), 64'd1);
    check("t4_busy", 64'(busy), 64'd1);
    tick();
    @(negedge clock);
    check("t4_done_after", 64'(done), 64'd0);
    check("t4_busy_after", 64'(busy), 64'd0);
    tick();
    go(2, 0, s);
    @(negedge clock);
    check("t4b_done", 64'(done), 64'd1);
    repeat (2) tick();
    check("t4_nreads", 64'(rd_cyc.size()), 64'd0);
    check("t4_ndone", 64'(done_cyc.size()), 64'd2);

    // Reset in the middle of a sweep, then a short drain
    clr();
    go(3, 8, s);
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check_idle_outputs("t5_async");
    clr();
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    check("t5_no_done", 64'(done_cyc.size()), 64'd0);
    check("t5_no_reads", 64'(rd_cyc.size()), 64'd0);
    go(1, 4, s);
    repeat (4) tick();
    expect_sweep("t5", s, 1, 4);
    if (ac_data.size() == 1) check("t5_w0_hand", 64'(ac_data[0]), 64'h03020100);

    // Second start mid-sweep must be ignored
    clr();
    go(2, 8, s);
    tick();
    rows_valid = 3'd1;
    cols_valid = 4'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    rows_valid = 3'd3;
    repeat (7) tick();
    expect_sweep("t6", s, 2, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
